// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, ALU
// operation codes, state codes and the opcode decode helpers.
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_FUNCT   = 4'd2,
        ALU_IMM_ADD = 4'd3,
        ALU_SLT_IMM = 4'd4,
        ALU_AND     = 4'd5,
        ALU_OR      = 4'd6,
        ALU_LUI     = 4'd7
    } aluOpT;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        MEM_WR = 4'd7,
        WB_R   = 4'd8,
        WB_I   = 4'd9,
        WB_MEM = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        JAL    = 4'd13
    } stateT;

    // State following DECODE; unsupported opcodes fall back to FETCH.
    function automatic stateT decodeNext(input logic [5:0] op);
        case (op)
            OP_RTYPE:                 return EXEC_R;
            OP_J:                     return JUMP;
            OP_JAL:                   return JAL;
            OP_BEQ, OP_BNE:           return BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI:  return EXEC_I;
            OP_LW, OP_SW:             return ADDR;
            default:                  return FETCH;
        endcase
    endfunction

    // ALU operation for the immediate-arithmetic group.
    function automatic aluOpT immAluOp(input logic [5:0] op);
        case (op)
            OP_SLTI, OP_SLTIU: return ALU_SLT_IMM;
            OP_ANDI:           return ALU_AND;
            OP_ORI:            return ALU_OR;
            OP_LUI:            return ALU_LUI;
            default:           return ALU_IMM_ADD;
        endcase
    endfunction

    // Logical immediates and addiu take a zero-extended immediate.
    function automatic logic immSignExt(input logic [5:0] op);
        return !(op == OP_ADDIU || op == OP_ANDI || op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake in,
// every mux select / write strobe out. master = controller side.
interface multicycle_control_if;
    logic [5:0] OpCode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       selectRaWire;
    logic       zeroImm;
    logic       extendType;
    logic       bneSelect;
    logic       IllegalOp;
    logic       BusError;
    logic [3:0] State;

    modport master (
        input  OpCode, MemReady,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, selectRaWire, zeroImm, extendType, bneSelect,
               IllegalOp, BusError, State
    );

    modport slave (
        output OpCode, MemReady,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, selectRaWire, zeroImm, extendType, bneSelect,
               IllegalOp, BusError, State
    );
endinterface

// File: rtl/multicycle_control_timer.sv
// Memory wait-state watchdog. Only built when MEM_TIMEOUT_EN is defined.
// Counts consecutive MemReady=0 cycles in a waiting state; any cycle that
// is not a wait (ready, or a non-memory state) restarts the count, so the
// count is always zero on entry to FETCH/MEM_RD/MEM_WR.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic waitCycle,
    output logic expired,
    output logic busError
);
    logic [3:0] waitCnt;

    // Fires on the LIMIT-th stalled cycle; a ready on that cycle never fires.
    assign expired = waitCycle && (waitCnt == 4'(LIMIT - 1));

    // Stall counter, restarted by any non-wait cycle or by the abort itself.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 waitCnt <= '0;
        else if (!waitCycle || expired) waitCnt <= '0;
        else                          waitCnt <= waitCnt + 4'd1;
    end

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     busError <= 1'b0;
        else if (expired) busError <= 1'b1;
    end
endmodule
`endif

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback.
// Outputs are decoded from the state register; IRWrite/PCWrite in FETCH
// follow MemReady directly. Define MEM_TIMEOUT_EN to add a memory wait
// watchdog that aborts a stalled access and raises a sticky BusError.
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    multicycle_control_if.master bus
);
    stateT state;
    aluOpT aluOp;
    logic  timeoutHit;

    // The wait counter is 4 bits wide, so the limit must fit in it.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15) begin : gBadTimeout
        $error("MEM_TIMEOUT must be in 1..15");
    end

`ifdef MEM_TIMEOUT_EN
    logic waitCycle;
    logic busErr;

    assign waitCycle = (state == FETCH || state == MEM_RD || state == MEM_WR)
                       && !bus.MemReady;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) uTimer (
        .clock    (clock),
        .reset_n  (reset_n),
        .waitCycle(waitCycle),
        .expired  (timeoutHit),
        .busError (busErr)
    );

    assign bus.BusError = busErr;
`else
    assign timeoutHit   = 1'b0;
    assign bus.BusError = 1'b0;
`endif

    // State sequencing; a memory ready always beats a same-cycle timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:   state <= FETCH;
                FETCH:  if (bus.MemReady)   state <= DECODE;
                        else if (timeoutHit) state <= IDLE;
                DECODE: state <= decodeNext(bus.OpCode);
                EXEC_R: state <= WB_R;
                WB_R:   state <= FETCH;
                EXEC_I: state <= WB_I;
                WB_I:   state <= FETCH;
                ADDR:   state <= (bus.OpCode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD: if (bus.MemReady)   state <= WB_MEM;
                        else if (timeoutHit) state <= FETCH;
                WB_MEM: state <= FETCH;
                MEM_WR: if (bus.MemReady || timeoutHit) state <= FETCH;
                BRANCH: state <= FETCH;
                JUMP:   state <= FETCH;
                JAL:    state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

    // Per-state datapath controls; everything idles at 0 except sign extend.
    always_comb begin
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.IorD         = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'd0;
        bus.PCSource     = 2'd0;
        bus.selectRaWire = 1'b0;
        bus.zeroImm      = 1'b0;
        bus.extendType   = 1'b1;
        bus.bneSelect    = 1'b0;
        bus.IllegalOp    = 1'b0;
        aluOp            = ALU_ADD;
        case (state)
            FETCH: begin
                // PC+4 computed every cycle; commit only once the word lands.
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            DECODE: begin
                // Speculative branch target into ALUOut.
                bus.ALUSrcB   = 2'd3;
                bus.IllegalOp = (decodeNext(bus.OpCode) == FETCH);
            end
            EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                aluOp       = ALU_FUNCT;
            end
            WB_R: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            EXEC_I: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'd2;
                aluOp          = immAluOp(bus.OpCode);
                bus.extendType = immSignExt(bus.OpCode);
            end
            WB_I: begin
                bus.RegWrite = 1'b1;
                aluOp        = immAluOp(bus.OpCode);
            end
            ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            WB_MEM: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                aluOp           = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'd1;
                bus.bneSelect   = (bus.OpCode == OP_BNE);
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'd2;
            end
            JAL: begin
                // Jump while PC (already +4) + 0 is written to $31.
                bus.PCWrite      = 1'b1;
                bus.PCSource     = 2'd2;
                bus.RegWrite     = 1'b1;
                bus.selectRaWire = 1'b1;
                bus.zeroImm      = 1'b1;
                bus.ALUSrcB      = 2'd2;
                aluOp            = ALU_IMM_ADD;
            end
            default: ;
        endcase
    end

    assign bus.ALUOp = aluOp;
    assign bus.State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of opcode/state-sequence vectors plus
// hand-written stall, reset-abort and (with MEM_TIMEOUT_EN) timeout cases.
// Expected controls come from a reference table of the control spec.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite;
        logic       memtoReg, regDst, regWrite, aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] pcSource;
        logic       selRa, zeroImm, extType, bneSel, illegal, busErr;
    } cwT;

    typedef struct packed {
        logic [3:0] st;
        cwT         cw;
    } expT;

    typedef struct packed {
        logic [5:0]      op;
        logic [2:0]      len;
        logic [4:0][3:0] seq;
    } vecT;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clock  (clk),
        .reset_n(rstN),
        .bus    (bus)
    );

    int   nTests = 0;
    int   nFail  = 0;
    expT  sb[$];
    logic expBusErr = 1'b0;
    vecT  vecs[16];
    cwT   actCw;

    assign actCw = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.IRWrite,
                    bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegDst,
                    bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                    bus.PCSource, bus.selectRaWire, bus.zeroImm,
                    bus.extendType, bus.bneSelect, bus.IllegalOp,
                    bus.BusError};

    function automatic logic [3:0] immOp(input logic [5:0] op);
        if (op == 6'd8 || op == 6'd9)   return 4'd3;
        if (op == 6'd10 || op == 6'd11) return 4'd4;
        if (op == 6'd12)                return 4'd5;
        if (op == 6'd13)                return 4'd6;
        return 4'd7;
    endfunction

    // Control word the spec requires in state st.
    function automatic cwT model(input logic [3:0] st, input logic [5:0] op,
                                 input logic mr, input logic be);
        cwT c;
        c = '0;
        c.extType = 1'b1;
        c.busErr  = be;
        case (st)
            4'd1:  begin c.memRead = 1; c.aluSrcB = 2'd1; c.irWrite = mr; c.pcWrite = mr; end
            4'd2:  begin
                c.aluSrcB = 2'd3;
                c.illegal = !(op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10,
                                         6'd11, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43});
            end
            4'd3:  begin c.aluSrcA = 1; c.aluOp = 4'd2; end
            4'd4:  begin
                c.aluSrcA = 1; c.aluSrcB = 2'd2; c.aluOp = immOp(op);
                c.extType = !(op inside {6'd9, 6'd12, 6'd13});
            end
            4'd5:  begin c.aluSrcA = 1; c.aluSrcB = 2'd2; end
            4'd6:  begin c.memRead = 1; c.iorD = 1; end
            4'd7:  begin c.memWrite = 1; c.iorD = 1; end
            4'd8:  begin c.regDst = 1; c.regWrite = 1; end
            4'd9:  begin c.regWrite = 1; c.aluOp = immOp(op); end
            4'd10: begin c.memtoReg = 1; c.regWrite = 1; end
            4'd11: begin
                c.aluSrcA = 1; c.aluOp = 4'd1; c.pcWriteCond = 1;
                c.pcSource = 2'd1; c.bneSel = (op == 6'd5);
            end
            4'd12: begin c.pcWrite = 1; c.pcSource = 2'd2; end
            4'd13: begin
                c.pcWrite = 1; c.pcSource = 2'd2; c.regWrite = 1; c.selRa = 1;
                c.zeroImm = 1; c.aluSrcB = 2'd2; c.aluOp = 4'd3;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic vecT mk(input int op, input int len, input int s0, input int s1,
                               input int s2, input int s3, input int s4);
        vecT v;
        v.op  = 6'(op);
        v.len = 3'(len);
        v.seq = {4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
        return v;
    endfunction

    task automatic push(input logic mr, input logic [3:0] st);
        expT e;
        e.st = st;
        e.cw = model(st, bus.OpCode, mr, expBusErr);
        sb.push_back(e);
    endtask

    task automatic check();
        expT e;
        e = sb.pop_front();
        nTests++;
        if (bus.State !== e.st) begin
            nFail++;
            $display("FAIL state t=%0t got=%0d want=%0d", $time, bus.State, e.st);
        end
        nTests++;
        if (actCw !== e.cw) begin
            nFail++;
            $display("FAIL ctrl t=%0t st=%0d op=%0d got=%h want=%h",
                     $time, e.st, bus.OpCode, actCw, e.cw);
        end
    endtask

    // One clock cycle: drive MemReady, expect state st, sample at negedge.
    task automatic step(input logic mr, input logic [3:0] st);
        bus.MemReady = mr;
        push(mr, st);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0,  4, 1, 2, 3, 8, 0);
        vecs[1]  = mk(8,  4, 1, 2, 4, 9, 0);
        vecs[2]  = mk(9,  4, 1, 2, 4, 9, 0);
        vecs[3]  = mk(10, 4, 1, 2, 4, 9, 0);
        vecs[4]  = mk(11, 4, 1, 2, 4, 9, 0);
        vecs[5]  = mk(12, 4, 1, 2, 4, 9, 0);
        vecs[6]  = mk(13, 4, 1, 2, 4, 9, 0);
        vecs[7]  = mk(15, 4, 1, 2, 4, 9, 0);
        vecs[8]  = mk(35, 5, 1, 2, 5, 6, 10);
        vecs[9]  = mk(43, 4, 1, 2, 5, 7, 0);
        vecs[10] = mk(4,  3, 1, 2, 11, 0, 0);
        vecs[11] = mk(5,  3, 1, 2, 11, 0, 0);
        vecs[12] = mk(2,  3, 1, 2, 12, 0, 0);
        vecs[13] = mk(3,  3, 1, 2, 13, 0, 0);
        vecs[14] = mk(36, 2, 1, 2, 0, 0, 0);
        vecs[15] = mk(63, 2, 1, 2, 0, 0, 0);

        bus.OpCode   = 6'd0;
        bus.MemReady = 1'b1;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        push(1'b1, 4'd0);
        check();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step(1'b1, 4'd0);

        // Table: every opcode class with zero wait states.
        for (int i = 0; i < 16; i++) begin
            bus.OpCode = vecs[i].op;
            for (int k = 0; k < int'(vecs[i].len); k++)
                step(1'b1, vecs[i].seq[k]);
        end

        // lw with two wait states in MEM_RD: 7 cycles total.
        bus.OpCode = 6'd35;
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd5);
        step(1'b0, 4'd6); step(1'b0, 4'd6); step(1'b1, 4'd6);
        step(1'b1, 4'd10);

        // Fetch stall: IRWrite/PCWrite only on the ready cycle.
        bus.OpCode = 6'd0;
        step(1'b0, 4'd1); step(1'b0, 4'd1); step(1'b1, 4'd1);
        step(1'b1, 4'd2); step(1'b1, 4'd3); step(1'b1, 4'd8);

        // sw into a long stall.
        bus.OpCode = 6'd43;
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd5);
`ifdef MEM_TIMEOUT_EN
        // Ready arriving on the limit cycle completes normally.
        for (int i = 0; i < 14; i++) step(1'b0, 4'd7);
        step(1'b1, 4'd7);
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd5);
        // 15 stalled cycles abort to FETCH with sticky BusError.
        for (int i = 0; i < 15; i++) step(1'b0, 4'd7);
        expBusErr = 1'b1;
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd5);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd7);
`else
        for (int i = 0; i < 20; i++) step(1'b0, 4'd7);
`endif

        // Asynchronous reset in the middle of MEM_WR.
        #2;
        rstN = 1'b0;
        expBusErr = 1'b0;
        push(1'b0, 4'd0);
        #1;
        check();
        @(negedge clk);
        push(1'b0, 4'd0);
        check();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        step(1'b1, 4'd0);
        step(1'b1, 4'd1); step(1'b1, 4'd2); step(1'b1, 4'd5);
        step(1'b1, 4'd7); step(1'b1, 4'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
